// File: rtl/montgomery_mult_param.sv
// Radix-2 Montgomery multiplier: out = A*B*2^(-W) mod N, valid/ready on both sides.
// Optional macro MONT_ODD_CHECK_EN adds an err output that flags an even modulus.
module montgomery_mult_param #(
  parameter int W  = 256,
  parameter int CW = $clog2(W+1)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  input  logic [W-1:0] N,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out,
  output logic         busy
`ifdef MONT_ODD_CHECK_EN
  ,
  output logic         err
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ITER,
    S_SUB,
    S_DONE
  } state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic [W-1:0]   n_q, n_d;
  logic [W+1:0]   acc_q, acc_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           err_q, err_d;

  // One spare bit above acc so t + N cannot overflow before the shift.
  logic [W+2:0]   t_sum;
  logic [W+2:0]   r_sum;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      n_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      n_q     <= n_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    n_d     = n_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    err_d   = err_q;

    // a_q is shifted right every iteration, so a_q[0] is always bit cnt of A.
    t_sum = {1'b0, acc_q} + (a_q[0] ? {3'b000, b_q} : '0);
    r_sum = t_sum + (t_sum[0] ? {3'b000, n_q} : '0);

    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = A;
          b_d     = B;
          n_d     = N;
          acc_d   = '0;
          cnt_d   = '0;
          err_d   = 1'b0;
          state_d = S_ITER;
`ifdef MONT_ODD_CHECK_EN
          if (!N[0]) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end
`endif
        end
      end
      S_ITER: begin
        acc_d = (W+2)'(r_sum >> 1);
        a_d   = a_q >> 1;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(W-1)) state_d = S_SUB;
      end
      S_SUB: begin
        if (acc_q >= {2'b00, n_q}) acc_d = acc_q - {2'b00, n_q};
        state_d = S_DONE;
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
          err_d   = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q == S_ITER) || (state_q == S_SUB);
  assign out       = acc_q[W-1:0];

`ifdef MONT_ODD_CHECK_EN
  assign err = err_q;
`else
  // Without the odd check err_q is held at zero; fold it in so nothing dangles.
  logic unused_err;
  assign unused_err = err_q;
`endif

endmodule

// File: tb/tb_montgomery_mult_param.sv
// Bench for montgomery_mult_param: W=8 and W=256 instances checked against a modular-halving model.
module tb_montgomery_mult_param;

  logic clk = 1'b0;
  logic reset;

  logic       v8, r8_out, ir8, ov8, busy8;
  logic [7:0] a8, b8, n8, out8;

  logic         v256, r256_out, ir256, ov256, busy256;
  logic [255:0] a256, b256, n256, out256;

`ifdef MONT_ODD_CHECK_EN
  logic err8, err256;
`endif

  int tests = 0;
  int fails = 0;

  localparam logic [255:0] NBIG = {1'b1, 254'd0, 1'b1};

  always #5 clk = ~clk;

  montgomery_mult_param #(.W(8)) dut8 (
    .clk(clk), .reset(reset), .in_valid(v8), .in_ready(ir8),
    .A(a8), .B(b8), .N(n8), .out_valid(ov8), .out_ready(r8_out),
    .out(out8), .busy(busy8)
`ifdef MONT_ODD_CHECK_EN
    , .err(err8)
`endif
  );

  montgomery_mult_param dut256 (
    .clk(clk), .reset(reset), .in_valid(v256), .in_ready(ir256),
    .A(a256), .B(b256), .N(n256), .out_valid(ov256), .out_ready(r256_out),
    .out(out256), .busy(busy256)
`ifdef MONT_ODD_CHECK_EN
    , .err(err256)
`endif
  );

  // (a*b mod n) halved w times modulo n, i.e. a*b*2^-w mod n.
  function automatic logic [255:0] ref_mont(input logic [255:0] a, input logic [255:0] b,
                                            input logic [255:0] n, input int w);
    logic [511:0] p;
    logic [257:0] x;
    p = (512'(a) * 512'(b)) % 512'(n);
    x = 258'(p[255:0]);
    for (int i = 0; i < w; i++) x = x[0] ? ((x + 258'(n)) >> 1) : (x >> 1);
    return x[255:0];
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start8(input logic [7:0] a, input logic [7:0] b, input logic [7:0] n);
    a8 = a; b8 = b; n8 = n; v8 = 1'b1;
    tick();
    v8 = 1'b0;
  endtask

  task automatic wait8(output int lat);
    lat = 1;
    while (!ov8 && lat < 100) begin
      tick();
      lat++;
    end
  endtask

  task automatic accept8();
    r8_out = 1'b1;
    tick();
    r8_out = 1'b0;
  endtask

  task automatic start256(input logic [255:0] a, input logic [255:0] b, input logic [255:0] n);
    a256 = a; b256 = b; n256 = n; v256 = 1'b1;
    tick();
    v256 = 1'b0;
  endtask

  task automatic wait256(output int lat);
    lat = 1;
    while (!ov256 && lat < 400) begin
      tick();
      lat++;
    end
  endtask

  task automatic accept256();
    r256_out = 1'b1;
    tick();
    r256_out = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    tests++;
    if (ir8 !== 1'b1 || ov8 !== 1'b0 || busy8 !== 1'b0 || out8 !== 8'd0) begin
      fails++;
      $display("FAIL reset8: in_ready=%b out_valid=%b busy=%b out=%0d, want 1 0 0 0", ir8, ov8, busy8, out8);
    end
    tests++;
    if (ir256 !== 1'b1 || ov256 !== 1'b0 || busy256 !== 1'b0 || out256 !== '0) begin
      fails++;
      $display("FAIL reset256: in_ready=%b out_valid=%b busy=%b out=%h", ir256, ov256, busy256, out256);
    end
`ifdef MONT_ODD_CHECK_EN
    tests++;
    if (err8 !== 1'b0) begin
      fails++;
      $display("FAIL reset_err: err=%b want 0", err8);
    end
`endif
    reset = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    int lat;
    logic [255:0] exp;
    exp = ref_mont(5, 7, 13, 8);
    start8(8'd5, 8'd7, 8'd13);
    tests++;
    if (busy8 !== 1'b1 || ir8 !== 1'b0) begin
      fails++;
      $display("FAIL basic_busy: busy=%b in_ready=%b want 1 0", busy8, ir8);
    end
    wait8(lat);
    tests++;
    if (lat != 10) begin
      fails++;
      $display("FAIL basic_latency: got %0d cycles want 10", lat);
    end
    tests++;
    if (out8 !== exp[7:0] || exp[7:0] !== 8'd1) begin
      fails++;
      $display("FAIL basic_out: got %0d want %0d (expected 1)", out8, exp[7:0]);
    end
    accept8();
    tests++;
    if (ov8 !== 1'b0 || ir8 !== 1'b1) begin
      fails++;
      $display("FAIL basic_release: out_valid=%b in_ready=%b want 0 1", ov8, ir8);
    end
  endtask

  task automatic test_hold();
    int lat;
    logic [255:0] exp;
    exp = ref_mont(12, 12, 13, 8);
    start8(8'd12, 8'd12, 8'd13);
    wait8(lat);
    for (int i = 0; i < 5; i++) begin
      tests++;
      if (ov8 !== 1'b1 || out8 !== exp[7:0]) begin
        fails++;
        $display("FAIL hold_stable[%0d]: out_valid=%b out=%0d want 1 %0d", i, ov8, out8, exp[7:0]);
      end
      tick();
    end
    tests++;
    if (ov8 !== 1'b1 || out8 !== 8'd3) begin
      fails++;
      $display("FAIL hold_final: out_valid=%b out=%0d want 1 3", ov8, out8);
    end
    accept8();
    tests++;
    if (ov8 !== 1'b0) begin
      fails++;
      $display("FAIL hold_release: out_valid=%b want 0", ov8);
    end
  endtask

  task automatic test_ignore_in_valid();
    int lat;
    int bad_ready;
    start8(8'd0, 8'd9, 8'd13);
    bad_ready = 0;
    tick();
    a8 = 8'd1; v8 = 1'b1;
    if (ir8 !== 1'b0) bad_ready++;
    tick();
    v8 = 1'b0;
    lat = 3;
    while (!ov8 && lat < 100) begin
      if (ir8 !== 1'b0) bad_ready++;
      tick();
      lat++;
    end
    tests++;
    if (bad_ready != 0) begin
      fails++;
      $display("FAIL ignore_ready: in_ready high on %0d busy cycles want 0", bad_ready);
    end
    tests++;
    if (lat != 10 || out8 !== 8'd0) begin
      fails++;
      $display("FAIL ignore_out: lat=%0d out=%0d want 10 0", lat, out8);
    end
    accept8();
  endtask

  task automatic test_reset_mid();
    int lat;
    logic [255:0] exp;
    start8(8'd1, 8'd1, 8'd13);
    tick();
    tick();
    tick();
    tests++;
    if (busy8 !== 1'b1) begin
      fails++;
      $display("FAIL midreset_busy: busy=%b want 1", busy8);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tests++;
    if (ir8 !== 1'b1 || ov8 !== 1'b0 || busy8 !== 1'b0 || out8 !== 8'd0) begin
      fails++;
      $display("FAIL midreset_state: in_ready=%b out_valid=%b busy=%b out=%0d want 1 0 0 0", ir8, ov8, busy8, out8);
    end
    exp = ref_mont(5, 7, 13, 8);
    start8(8'd5, 8'd7, 8'd13);
    wait8(lat);
    tests++;
    if (lat != 10 || out8 !== exp[7:0]) begin
      fails++;
      $display("FAIL midreset_next: lat=%0d out=%0d want 10 %0d", lat, out8, exp[7:0]);
    end
    accept8();
  endtask

  task automatic test_random8();
    int lat;
    logic [7:0] n, a, b;
    logic [255:0] exp;
    for (int k = 0; k < 20; k++) begin
      n = 8'($urandom_range(3, 255) | 1);
      a = 8'($urandom_range(0, int'(n) - 1));
      b = 8'($urandom_range(0, int'(n) - 1));
      exp = ref_mont(a, b, n, 8);
      start8(a, b, n);
      wait8(lat);
      tests++;
      if (lat != 10 || out8 !== exp[7:0]) begin
        fails++;
        $display("FAIL rand8[%0d] %0d*%0d mod %0d: lat=%0d out=%0d want 10 %0d", k, a, b, n, lat, out8, exp[7:0]);
      end
      accept8();
    end
  endtask

  task automatic test_wide();
    int lat;
    logic [255:0] n, a, b, exp;
    for (int k = 0; k < 3; k++) begin
      if (k == 0) begin
        n = NBIG; a = 256'd2; b = 256'd3;
      end else begin
        n = rand256();
        n[0] = 1'b1;
        n[255] = 1'b1;
        a = rand256() % n;
        b = rand256() % n;
      end
      exp = ref_mont(a, b, n, 256);
      start256(a, b, n);
      wait256(lat);
      tests++;
      if (lat != 258 || out256 !== exp) begin
        fails++;
        $display("FAIL wide[%0d]: lat=%0d out=%h want 258 %h", k, lat, out256, exp);
      end
      accept256();
    end
  endtask

  task automatic test_back_to_back();
    logic [255:0] a2, b2, n2, e1, e2;
    logic [255:0] res [2];
    int accepted, nres;
    bit hs, take;
    n2 = rand256();
    n2[0] = 1'b1;
    n2[255] = 1'b1;
    a2 = rand256() % n2;
    b2 = rand256() % n2;
    e1 = ref_mont(2, 3, NBIG, 256);
    e2 = ref_mont(a2, b2, n2, 256);
    accepted = 0;
    nres = 0;
    r256_out = 1'b1;
    a256 = 256'd2; b256 = 256'd3; n256 = NBIG; v256 = 1'b1;
    for (int c = 0; c < 1200 && nres < 2; c++) begin
      hs = ir256 && v256;
      take = ov256;
      if (take) begin
        res[nres] = out256;
        tests++;
        if (ir256 !== 1'b0) begin
          fails++;
          $display("FAIL b2b_ready_in_done: in_ready=%b want 0", ir256);
        end
      end
      tick();
      if (take) nres++;
      if (hs) begin
        accepted++;
        if (accepted == 1) begin
          a256 = a2; b256 = b2; n256 = n2;
        end else begin
          v256 = 1'b0;
        end
      end
    end
    r256_out = 1'b0;
    v256 = 1'b0;
    tests++;
    if (nres != 2) begin
      fails++;
      $display("FAIL b2b_timeout: got %0d results want 2", nres);
    end else begin
      tests++;
      if (res[0] !== e1 || res[1] !== e2) begin
        fails++;
        $display("FAIL b2b_results: got %h %h want %h %h", res[0], res[1], e1, e2);
      end
    end
  endtask

`ifdef MONT_ODD_CHECK_EN
  task automatic test_odd_check();
    int lat;
    start8(8'd3, 8'd4, 8'd12);
    lat = 1;
    while (!ov8 && lat < 20) begin
      tick();
      lat++;
    end
    tests++;
    if (ov8 !== 1'b1 || lat > 2 || out8 !== 8'd0 || err8 !== 1'b1) begin
      fails++;
      $display("FAIL odd_check: out_valid=%b lat=%0d out=%0d err=%b want 1 <=2 0 1", ov8, lat, out8, err8);
    end
    accept8();
    tests++;
    if (err8 !== 1'b0 || ov8 !== 1'b0) begin
      fails++;
      $display("FAIL odd_clear: err=%b out_valid=%b want 0 0", err8, ov8);
    end
  endtask
`endif

  initial begin
    reset = 1'b1;
    v8 = 1'b0; r8_out = 1'b0; a8 = '0; b8 = '0; n8 = '0;
    v256 = 1'b0; r256_out = 1'b0; a256 = '0; b256 = '0; n256 = '0;
    test_reset();
    test_basic();
    test_hold();
    test_ignore_in_valid();
    test_reset_mid();
    test_random8();
    test_wide();
    test_back_to_back();
`ifdef MONT_ODD_CHECK_EN
    test_odd_check();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
